// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner: FSM encoding,
// column reset pattern, named key codes and small one-hot helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HOLD       = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_e;

    localparam logic [3:0] COL_INIT = 4'b0001;

    // Key code = row_idx*4 + col_idx, named so tops can decode commands
    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    // True when exactly one bit of the 4-bit vector is set
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Index of the set bit of a one-hot vector (0 for anything else)
    function automatic logic [1:0] onehot4_to_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Next column in the scan order 0001 -> 0010 -> 0100 -> 1000 -> 0001
    function automatic logic [3:0] rotate_col(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running scan tick divider: one-clk tick every SCAN_DIV clocks.
module keypad_tick_gen
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 125000
) (
    input  logic clk,
    input  logic reset_p,
    output logic tick
);

    localparam int             CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  LAST     = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  PRE_LAST = CW'(SCAN_DIV - 2);
    localparam logic [CW-1:0]  ONE      = CW'(1);
    localparam logic [CW-1:0]  ZERO     = CW'(0);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Counter wraps at SCAN_DIV-1; tick is registered so it is high exactly while r_cnt == LAST
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_cnt  <= ZERO;
            r_tick <= 1'b0;
        end else begin
            if (r_cnt == LAST) begin
                r_cnt <= ZERO;
            end else begin
                r_cnt <= r_cnt + ONE;
            end
            r_tick <= (r_cnt == PRE_LAST);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/keypad_4x4_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, press and
// release debouncing, and a single coded key event per press.
module keypad_4x4_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 125000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int             DBW       = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DBW-1:0] DB_ZERO   = DBW'(0);
    localparam logic [DBW-1:0] DB_ONE    = DBW'(1);
    localparam logic [DBW-1:0] DB_DONE   = DBW'(DEBOUNCE_TICKS);
    localparam logic           DB_SINGLE = (DEBOUNCE_TICKS == 1);

    logic            w_tick;
    logic [3:0]      r_row_meta;
    logic [3:0]      r_row_s;

    kp_state_e       r_state,       w_state_next;
    logic [3:0]      r_col,         w_col_next;
    logic [1:0]      r_col_idx,     w_col_idx_next;
    logic [3:0]      r_row_pat,     w_row_pat_next;
    logic [DBW-1:0]  r_db_cnt,      w_db_cnt_next;
    logic [3:0]      r_key_value,   w_key_value_next;
    logic            r_key_valid,   w_key_valid_next;
    logic            r_key_pressed, w_key_pressed_next;

    logic [DBW-1:0]  w_db_cnt_inc;
    logic [3:0]      w_acc_pat;
    logic [1:0]      w_acc_cidx;
    logic            w_acc_single;
    logic [3:0]      w_acc_code;

    keypad_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_p (reset_p),
        .tick    (w_tick)
    );

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_row_meta <= 4'b0000;
            r_row_s    <= 4'b0000;
        end else begin
            r_row_meta <= row;
            r_row_s    <= r_row_meta;
        end
    end

    // Acceptance uses live values when accepting straight out of SCAN, latched ones otherwise
    assign w_db_cnt_inc = r_db_cnt + DB_ONE;
    assign w_acc_pat    = (r_state == SCAN) ? r_row_s : r_row_pat;
    assign w_acc_cidx   = (r_state == SCAN) ? onehot4_to_idx(r_col) : r_col_idx;
    assign w_acc_single = is_onehot4(w_acc_pat);
    assign w_acc_code   = {onehot4_to_idx(w_acc_pat), w_acc_cidx};

    // Next-state and output logic; all decisions are taken on scan ticks only
    always_comb begin
        w_state_next       = r_state;
        w_col_next         = r_col;
        w_col_idx_next     = r_col_idx;
        w_row_pat_next     = r_row_pat;
        w_db_cnt_next      = r_db_cnt;
        w_key_value_next   = r_key_value;
        w_key_valid_next   = 1'b0;
        w_key_pressed_next = r_key_pressed;

        case (r_state)
            SCAN: begin
                if (!w_tick) begin
                    w_state_next = SCAN;
                end else if (r_row_s == 4'b0000) begin
                    w_col_next = rotate_col(r_col);
                end else begin
                    w_col_idx_next = onehot4_to_idx(r_col);
                    w_row_pat_next = r_row_s;
                    w_db_cnt_next  = DB_ONE;
                    if (!DB_SINGLE) begin
                        w_state_next = PRESS_DB;
                    end else if (w_acc_single) begin
                        w_key_value_next   = w_acc_code;
                        w_key_valid_next   = 1'b1;
                        w_key_pressed_next = 1'b1;
                        w_state_next       = HOLD;
                    end else begin
                        w_state_next = HOLD;
                    end
                end
            end

            PRESS_DB: begin
                if (!w_tick) begin
                    w_state_next = PRESS_DB;
                end else if (r_row_s != r_row_pat) begin
                    // Bounce: drop the candidate and move on to the next column
                    w_state_next = SCAN;
                    w_col_next   = rotate_col(r_col);
                end else begin
                    w_db_cnt_next = w_db_cnt_inc;
                    if (w_db_cnt_inc != DB_DONE) begin
                        w_state_next = PRESS_DB;
                    end else if (w_acc_single) begin
                        w_key_value_next   = w_acc_code;
                        w_key_valid_next   = 1'b1;
                        w_key_pressed_next = 1'b1;
                        w_state_next       = HOLD;
                    end else begin
                        // Ghost or multi-press: wait for release without an event
                        w_state_next = HOLD;
                    end
                end
            end

            HOLD: begin
                if (!w_tick || (r_row_s != 4'b0000)) begin
                    w_state_next = HOLD;
                end else begin
                    w_db_cnt_next = DB_ONE;
                    if (DB_SINGLE) begin
                        w_key_pressed_next = 1'b0;
                        w_col_next         = rotate_col(r_col);
                        w_state_next       = SCAN;
                    end else begin
                        w_state_next = RELEASE_DB;
                    end
                end
            end

            RELEASE_DB: begin
                if (!w_tick) begin
                    w_state_next = RELEASE_DB;
                end else if (r_row_s != 4'b0000) begin
                    w_state_next = HOLD;
                end else begin
                    w_db_cnt_next = w_db_cnt_inc;
                    if (w_db_cnt_inc == DB_DONE) begin
                        w_key_pressed_next = 1'b0;
                        w_col_next         = rotate_col(r_col);
                        w_state_next       = SCAN;
                    end else begin
                        w_state_next = RELEASE_DB;
                    end
                end
            end

            default: begin
                w_state_next       = SCAN;
                w_col_next         = COL_INIT;
                w_db_cnt_next      = DB_ZERO;
                w_key_pressed_next = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_state       <= SCAN;
            r_col         <= COL_INIT;
            r_col_idx     <= 2'd0;
            r_row_pat     <= 4'b0000;
            r_db_cnt      <= DB_ZERO;
            r_key_value   <= 4'h0;
            r_key_valid   <= 1'b0;
            r_key_pressed <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_col         <= w_col_next;
            r_col_idx     <= w_col_idx_next;
            r_row_pat     <= w_row_pat_next;
            r_db_cnt      <= w_db_cnt_next;
            r_key_value   <= w_key_value_next;
            r_key_valid   <= w_key_valid_next;
            r_key_pressed <= w_key_pressed_next;
        end
    end

    assign col         = r_col;
    assign key_value   = r_key_value;
    assign key_valid   = r_key_valid;
    assign key_pressed = r_key_pressed;

endmodule

// File: tb/tb_keypad_4x4_scanner.sv
// Directed bench for keypad_4x4_scanner with SCAN_DIV=4, DEBOUNCE_TICKS=3.
// The keypad is modelled combinationally: rows in tb_row_mask read high
// whenever a column in tb_col_mask is driven and tb_gate is high.
module tb_keypad_4x4_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic       clk     = 1'b0;
    logic       reset_p = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_pressed;

    logic [3:0] tb_col_mask = 4'b0000;
    logic [3:0] tb_row_mask = 4'b0000;
    logic       tb_gate     = 1'b1;

    int checks     = 0;
    int failures   = 0;
    int pulse_cnt  = 0;

    keypad_4x4_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEB)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .row         (row),
        .col         (col),
        .key_value   (key_value),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    always #5 clk = ~clk;

    always_comb row = ((|(col & tb_col_mask)) && tb_gate) ? tb_row_mask : 4'b0000;

    always @(negedge clk) begin
        if (key_valid === 1'b1) pulse_cnt++;
    end

    // Advance n clocks; sample point is just after each falling edge
    task automatic step_n(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_col(input logic [3:0] target, input string name);
        int n;
        n = 0;
        while ((col !== target) && (n < 40)) begin
            step_n(1);
            n++;
        end
        checks++;
        if (col !== target) begin
            failures++;
            $display("FAIL %s timeout col=%b wanted=%b", name, col, target);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100;
        exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0001;
        reset_p = 1'b1;
        step_n(3);
        checks++; if (col !== 4'b0001) begin failures++; $display("FAIL reset_col got=%b exp=0001", col); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        checks++; if (key_pressed !== 1'b0) begin failures++; $display("FAIL reset_pressed got=%b exp=0", key_pressed); end
        checks++; if (key_value !== 4'h0) begin failures++; $display("FAIL reset_value got=%h exp=0", key_value); end
        reset_p = 1'b0;
        step_n(3);
        checks++; if (col !== 4'b0001) begin failures++; $display("FAIL rot_early got=%b exp=0001", col); end
        step_n(1);
        checks++; if (col !== exp_seq[0]) begin failures++; $display("FAIL rot_0 got=%b exp=%b", col, exp_seq[0]); end
        for (int i = 1; i < 4; i++) begin
            step_n(4);
            checks++;
            if (col !== exp_seq[i]) begin failures++; $display("FAIL rot_%0d got=%b exp=%b", i, col, exp_seq[i]); end
        end
    endtask

    task automatic test_single_key();
        int p0;
        int n;
        p0 = pulse_cnt;
        wait_col(4'b0001, "single_pre");
        tb_col_mask = 4'b0010;
        tb_row_mask = 4'b0100;
        wait_col(4'b0010, "single_col");
        n = 0;
        while ((key_valid !== 1'b1) && (n < 40)) begin
            step_n(1);
            n++;
        end
        checks++; if (n != 12) begin failures++; $display("FAIL single_latency got=%0d exp=12", n); end
        checks++; if (key_value !== 4'd9) begin failures++; $display("FAIL single_value got=%0d exp=9", key_value); end
        checks++; if (key_pressed !== 1'b1) begin failures++; $display("FAIL single_pressed got=%b exp=1", key_pressed); end
        step_n(1);
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b exp=0", key_valid); end
        step_n(30);
        checks++; if (col !== 4'b0010) begin failures++; $display("FAIL single_frozen got=%b exp=0010", col); end
        checks++; if (key_pressed !== 1'b1) begin failures++; $display("FAIL single_hold got=%b exp=1", key_pressed); end
        checks++; if ((pulse_cnt - p0) != 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", pulse_cnt - p0); end
    endtask

    task automatic test_release_debounce();
        int p0;
        int n;
        bit dropped;
        p0 = pulse_cnt;
        dropped = 1'b0;
        tb_row_mask = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            step_n(1);
            if (key_pressed !== 1'b1) dropped = 1'b1;
        end
        tb_row_mask = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step_n(1);
            if (key_pressed !== 1'b1) dropped = 1'b1;
        end
        checks++; if (dropped) begin failures++; $display("FAIL rel_glitch got=pressed_low exp=pressed_high"); end
        tb_row_mask = 4'b0000;
        n = 0;
        while ((key_pressed !== 1'b0) && (n < 40)) begin
            step_n(1);
            n++;
        end
        checks++; if (n != 13) begin failures++; $display("FAIL rel_latency got=%0d exp=13", n); end
        checks++; if (col !== 4'b0100) begin failures++; $display("FAIL rel_rotate got=%b exp=0100", col); end
        step_n(4);
        checks++; if (col !== 4'b1000) begin failures++; $display("FAIL rel_resume got=%b exp=1000", col); end
        checks++; if ((pulse_cnt - p0) != 0) begin failures++; $display("FAIL rel_pulses got=%0d exp=0", pulse_cnt - p0); end
        tb_col_mask = 4'b0000;
    endtask

    task automatic test_bounce();
        int p0;
        int n;
        int changes;
        logic [3:0] prev;
        p0 = pulse_cnt;
        changes = 0;
        prev = col;
        tb_col_mask = 4'b1000;
        tb_row_mask = 4'b0001;
        for (int k = 0; k < 15; k++) begin
            tb_gate = 1'b1;
            for (int i = 0; i < 4; i++) begin
                step_n(1);
                if (col !== prev) changes++;
                prev = col;
            end
            tb_gate = 1'b0;
            for (int i = 0; i < 4; i++) begin
                step_n(1);
                if (col !== prev) changes++;
                prev = col;
            end
        end
        checks++; if ((pulse_cnt - p0) != 0) begin failures++; $display("FAIL bounce_pulses got=%0d exp=0", pulse_cnt - p0); end
        checks++; if (changes < 10) begin failures++; $display("FAIL bounce_rotation got=%0d exp>=10", changes); end
        tb_gate = 1'b1;
        n = 0;
        while ((key_valid !== 1'b1) && (n < 60)) begin
            step_n(1);
            n++;
        end
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL bounce_steady_valid got=%b exp=1", key_valid); end
        checks++; if (key_value !== 4'd3) begin failures++; $display("FAIL bounce_value got=%0d exp=3", key_value); end
        tb_row_mask = 4'b0000;
        n = 0;
        while ((key_pressed !== 1'b0) && (n < 40)) begin
            step_n(1);
            n++;
        end
        checks++; if (key_pressed !== 1'b0) begin failures++; $display("FAIL bounce_release got=%b exp=0", key_pressed); end
        checks++; if ((pulse_cnt - p0) != 1) begin failures++; $display("FAIL bounce_total got=%0d exp=1", pulse_cnt - p0); end
        tb_col_mask = 4'b0000;
    endtask

    task automatic test_multi_press();
        int p0;
        bit moved;
        p0 = pulse_cnt;
        moved = 1'b0;
        tb_col_mask = 4'b0001;
        tb_row_mask = 4'b1010;
        step_n(60);
        checks++; if (col !== 4'b0001) begin failures++; $display("FAIL multi_col got=%b exp=0001", col); end
        checks++; if (key_pressed !== 1'b0) begin failures++; $display("FAIL multi_pressed got=%b exp=0", key_pressed); end
        checks++; if (key_value !== 4'd3) begin failures++; $display("FAIL multi_value got=%0d exp=3", key_value); end
        tb_row_mask = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            step_n(1);
            if (col !== 4'b0001) moved = 1'b1;
        end
        checks++; if (moved) begin failures++; $display("FAIL multi_partial_release got=moved exp=frozen"); end
        tb_row_mask = 4'b0000;
        wait_col(4'b0010, "multi_resume");
        checks++; if ((pulse_cnt - p0) != 0) begin failures++; $display("FAIL multi_pulses got=%0d exp=0", pulse_cnt - p0); end
        tb_col_mask = 4'b0000;
    endtask

    task automatic test_reset_mid();
        int p0;
        tb_col_mask = 4'b0100;
        tb_row_mask = 4'b0010;
        wait_col(4'b0100, "mid_col");
        step_n(6);
        checks++; if (col !== 4'b0100) begin failures++; $display("FAIL mid_frozen got=%b exp=0100", col); end
        reset_p = 1'b1;
        #1;
        checks++; if (col !== 4'b0001) begin failures++; $display("FAIL mid_col_async got=%b exp=0001", col); end
        checks++; if (key_value !== 4'h0) begin failures++; $display("FAIL mid_value got=%h exp=0", key_value); end
        checks++; if ((key_valid !== 1'b0) || (key_pressed !== 1'b0)) begin
            failures++; $display("FAIL mid_flags got=%b%b exp=00", key_valid, key_pressed);
        end
        step_n(2);
        tb_row_mask = 4'b0000;
        p0 = pulse_cnt;
        reset_p = 1'b0;
        step_n(40);
        checks++; if ((pulse_cnt - p0) != 0) begin failures++; $display("FAIL mid_pulses got=%0d exp=0", pulse_cnt - p0); end
        checks++; if (key_value !== 4'h0) begin failures++; $display("FAIL mid_value_after got=%h exp=0", key_value); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_release_debounce();
        test_bounce();
        test_multi_press();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_4x4_scanner.md
Name: keypad_4x4_scanner

Overview:
- Input-side counterpart to the 4-digit FND scanning controller: drives a 4x4 matrix keypad one column at a time, samples the rows, debounces, and emits one coded key event per press.
- Sits beside the display controller in stopwatch/clock tops and replaces per-button debounce flip-flops as the user-input front end.
- Output key_valid pulses are the intended source for start/stop, lap and set commands.

Parameters:
- SCAN_DIV, 125000: clk cycles per scan tick (1 ms at 125 MHz). Minimum 2.
- DEBOUNCE_TICKS, 20: consecutive stable scan ticks needed to accept a press or a release. Minimum 1.

Ports:
- clk  input  1  system clock
- reset_p  input  1  asynchronous reset, active-high
- row  input  4  keypad row lines, active-high (pulled down externally), asynchronous to clk
- col  output  4  column drive, one-hot active-high
- key_value  output  4  code of the last accepted key = row_idx*4 + col_idx
- key_valid  output  1  one-clk pulse when a new key is accepted
- key_pressed  output  1  level; high from acceptance until debounced release

Behaviour:
- **Reset values:** col=4'b0001, key_value=0, key_valid=0, key_pressed=0, state=SCAN, all counters 0, synchronizer FFs 0.
- **Row sync:** row passes through a 2-FF synchronizer (row_s). All decisions use row_s and are evaluated only on scan-tick cycles.
- **Tick generator:**
  - Free-running counter 0..SCAN_DIV-1.
  - tick=1 for the single clk where the counter equals SCAN_DIV-1, then it wraps to 0.
  - The counter is never stopped by the FSM.
- **FSM states:** SCAN, PRESS_DB, HOLD, RELEASE_DB.
- **SCAN:**
  - On tick with row_s==0: rotate col left (0001→0010→0100→1000→0001).
  - On tick with row_s!=0: latch col index and row_s pattern, set db_cnt=1, go to PRESS_DB. col is frozen.
- **PRESS_DB** (on each tick):
  - If row_s equals the latched pattern: db_cnt++.
  - Else: go to SCAN with col rotated one step (no event).
  - When db_cnt reaches DEBOUNCE_TICKS with exactly one row bit set:
    - key_value = row_idx*4 + col_idx, key_valid=1 on the next clk only.
    - key_pressed=1, go to HOLD.
  - When db_cnt reaches DEBOUNCE_TICKS with more than one row bit set (ghost/multi-press): no pulse, key_value unchanged, key_pressed stays 0, go to HOLD.
  - DEBOUNCE_TICKS=1 accepts on the detecting tick itself.
- **HOLD:** col frozen. On tick with row_s==0: db_cnt=1, go to RELEASE_DB. Otherwise stay.
- **RELEASE_DB** (on each tick):
  - row_s==0: db_cnt++. On reaching DEBOUNCE_TICKS: key_pressed=0, rotate col, go to SCAN.
  - row_s!=0: return to HOLD.
- **Latency:**
  - key_valid rises exactly 1 clk after the tick on which acceptance occurs.
  - Bench rule of thumb: roughly 2 + SCAN_DIV*DEBOUNCE_TICKS clks after the row goes high while its column is driven.
- **key_value:** holds the last accepted code until the next acceptance or reset.
- **Key change without release:** a second key pressed while in HOLD is ignored. Only one event is produced per press/release cycle.
- **Reset mid-operation:** asynchronous return to the reset values regardless of state; a pending key_valid is cancelled.
- **Tick on the same clk as a row change:** the synchronized value on that clk is used; there is no lookahead.

Decomposition:
- Shared package keypad_pkg:
  - state encoding (SCAN=0, PRESS_DB=1, HOLD=2, RELEASE_DB=3);
  - COL_INIT=4'b0001;
  - named key codes (KEY_0..KEY_F), so tops can decode commands by name.
- One sub-module: keypad_tick_gen (parameter SCAN_DIV; ports clk, reset_p, tick). This mirrors the existing clock_usec/clock_msec dividers.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_TICKS=3.
1. **Reset:** assert reset_p for 3 clks, no keys → col=0001, key_valid=0, key_pressed=0, key_value=0; col then rotates every 4 clks through 0010, 0100, 1000, 0001.
2. **Single key:** model row[2] high whenever col[1]=1, held ≥30 clks → exactly one key_valid pulse, key_value=9 (2*4+1), key_pressed=1, col frozen at 0010.
3. **Bounce:** row[0] toggles while col[3]=1 with a high time of 1 tick between lows → no key_valid and col keeps rotating. Then hold row[0] steady → single pulse, key_value=3.
4. **Release debounce:** after scenario 2, drop the row for 2 ticks, reassert for 1 tick, then drop for ≥3 ticks → key_pressed stays 1 through the glitch, falls after 3 clean zero ticks; col resumes rotation; no extra key_valid.
5. **Multi-press:** row[1] and row[3] high while col[0]=1 → no key_valid, key_value unchanged, FSM in HOLD until both release.
6. **Reset mid-debounce:** assert reset_p during PRESS_DB → outputs return to reset values immediately; no key_valid is emitted afterward for that press unless it is re-detected and re-debounced.
